// File: rtl/spi_config_writer.sv
// SPI mode-0 slave that turns 32-bit host frames into one-cycle config-store write pulses.
// Optional MISO echo of the last accepted frame is built when SPI_CONFIG_ECHO_EN is defined.
module spi_config_writer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_TARGETS = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    input  logic                   i_SPI_Clock,
    input  logic                   i_SPI_MOSI,
    input  logic                   i_SPI_CS_n,
    output logic                   o_SPI_MISO,
    output logic [NUM_TARGETS-1:0] o_EnvelopeConfigWriteEnable,
    output logic [ADDR_WIDTH-1:0]  o_ConfigWriteAddr,
    output logic [15:0]            o_ConfigWriteData,
    output logic [7:0]             o_FrameErrorCount
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] settle_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    logic [1:0]             state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [31:0]            shift_q, shift_d;
    logic [NUM_TARGETS-1:0] en_q, en_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [15:0]            data_q, data_d;
    logic [7:0]             err_q, err_d;

    logic                   sck_s, mosi_s, csn_s;
    logic                   sck_rise, cs_fall, settled;
    logic                   frame_done, frame_valid;
    logic [31:0]            frame_next;
    logic [NUM_TARGETS-1:0] target_hit;

    assign sck_s   = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s   = csn_sync_q[SYNC_STAGES-1];
    assign settled = settle_q[SYNC_STAGES-1];

    // cs_prev_q only follows the bus once the synchronizers hold real samples, so a
    // CS_n already low across reset is never mistaken for a fresh falling edge.
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_fall  = settled & cs_prev_q & ~csn_s;

    assign frame_next = {shift_q[30:0], mosi_s};
    assign frame_done = (state_q == ST_SHIFT) && !csn_s && sck_rise && (cnt_q == 5'd31);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_target
            assign target_hit[gi] = (frame_next[31:24] == 8'(gi));
        end
    endgenerate
    assign frame_valid = |target_hit;

    // Write outputs are registered on the edge entering COMMIT so the pulse, address
    // and data are all valid together during the COMMIT cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        en_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (csn_s) begin
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    shift_d = frame_next;
                    cnt_d   = cnt_q + 5'd1;
                    if (frame_done) begin
                        state_d = ST_COMMIT;
                        if (frame_valid) begin
                            en_d   = target_hit;
                            addr_d = frame_next[16 +: ADDR_WIDTH];
                            data_d = frame_next[15:0];
                        end else if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                state_d = csn_s ? ST_IDLE : ST_SHIFT;
                cnt_d   = '0;
                if (sck_rise) begin
                    shift_d = frame_next;
                    cnt_d   = 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
            settle_q    <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            en_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            err_q       <= '0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_Clock};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
            settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            sck_prev_q  <= sck_s;
            if (settled) begin
                cs_prev_q <= csn_s;
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign o_EnvelopeConfigWriteEnable = en_q;
    assign o_ConfigWriteAddr           = addr_q;
    assign o_ConfigWriteData           = data_q;
    assign o_FrameErrorCount           = err_q;

`ifdef SPI_CONFIG_ECHO_EN
    logic        sck_fall;
    logic [31:0] echo_q;
    logic [31:0] tx_q;
    logic        tx_armed_q;

    assign sck_fall = ~sck_s & sck_prev_q;

    // tx_armed_q ignores the trailing SCK fall of the previous frame in a burst, so
    // bit 31 of the freshly loaded echo is not shifted out before it is sampled.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            echo_q     <= '0;
            tx_q       <= '0;
            tx_armed_q <= 1'b0;
        end else begin
            if (frame_done) begin
                echo_q <= frame_valid ? frame_next : 32'hFFFF_FFFF;
            end
            if (state_q == ST_IDLE) begin
                tx_q       <= echo_q;
                tx_armed_q <= 1'b0;
            end else if (state_q == ST_COMMIT) begin
                tx_q       <= echo_q;
                tx_armed_q <= sck_rise;
            end else begin
                if (sck_rise) begin
                    tx_armed_q <= 1'b1;
                end
                if (sck_fall && tx_armed_q) begin
                    tx_q <= {tx_q[30:0], 1'b0};
                end
            end
        end
    end

    assign o_SPI_MISO = tx_q[31];
`else
    assign o_SPI_MISO = 1'b0;
`endif

endmodule

// File: doc/spi_config_writer.md
Name: spi_config_writer

Overview:
SPI slave front end that turns host-MCU serial frames into the synchronous config-write bus consumed by the envelope stage and the other per-operator config stores. It resynchronizes SCK/MOSI/CS_n into i_Clock, assembles 32-bit frames and decodes the target field. For each valid frame it drives exactly one single-cycle write-enable pulse with a stable address and data.

Parameters:
ADDR_WIDTH, 8, width of the voice-operator address; must match `VOICE_OPERATOR_ID.
NUM_TARGETS, 5, number of write-enable lines; targets 0..4 are attack level, sustain level, attack rate, decay rate and release rate.
SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
i_Clock  in  1  system clock.
i_Reset_n  in  1  synchronous, active-low reset.
i_SPI_Clock  in  1  SPI SCK, mode 0, asynchronous to i_Clock.
i_SPI_MOSI  in  1  serial data, MSB first.
i_SPI_CS_n  in  1  chip select, active low.
o_SPI_MISO  out  1  serial out; echo when the optional feature is enabled, else constant 0.
o_EnvelopeConfigWriteEnable  out  NUM_TARGETS  one-hot, one-cycle write pulse.
o_ConfigWriteAddr  out  ADDR_WIDTH  voice-operator address.
o_ConfigWriteData  out  16  write data.
o_FrameErrorCount  out  8  saturating count of rejected frames.

Behaviour:
- Reset (i_Reset_n=0 at a rising i_Clock edge): all outputs 0; bit counter 0; shift register 0; FSM to IDLE; synchronizer outputs preset to the idle bus levels (SCK=0, CS_n=1).
- Synchronizer: SYNC_STAGES FFs per SPI input. A registered copy of the synced SCK provides rising-edge detection.
- Frame layout: [31:24] target, [23:16] address (lower ADDR_WIDTH bits used), [15:0] data.
- FSM:
  - IDLE: waits for synced CS_n=0, then goes to SHIFT with the bit counter cleared.
  - SHIFT: on each detected SCK rise, shifts in synced MOSI and increments the counter. When the 32nd bit is shifted in, goes to COMMIT. Synced CS_n=1 goes to IDLE and discards the partial frame with no write and no error.
  - COMMIT (one cycle): if target < NUM_TARGETS, drives enable bit [target]=1 and loads addr/data. Otherwise drives no enable and increments o_FrameErrorCount, saturating at 255. Then returns to SHIFT if CS_n is still low (burst: the next 32 bits form a new frame), else to IDLE.
- Latency: the enable pulse is high exactly in the i_Clock cycle after the cycle in which the 32nd SCK rise is detected.
- Enable is 0 in every other cycle. Addr/data are updated only in COMMIT and hold between writes.
- Rejected frames leave addr/data unchanged.
- Timing constraint: i_Clock ≥ 8× SCK. An SCK rise arriving during COMMIT is not lost; COMMIT still shifts that bit, which counts as bit 1 of the next frame.
- Reset asserted mid-frame: the partial frame is dropped. After reset, the first frame is taken only after a fresh synced CS_n falling edge.

Optional Feature:
SPI_CONFIG_ECHO_EN
- Defined: a 32-bit echo register loads the last accepted frame in COMMIT. During the next frame, o_SPI_MISO presents the echo MSB-first. Bit n is updated on each detected SCK fall, and bit 31 is driven while CS_n is low before the first edge. Rejected frames load 0xFFFFFFFF.
- Undefined: no echo logic; o_SPI_MISO tied to 0.

Test Plan:
1. Reset, then frame 0x02_1F_0ABC at SCK = i_Clock/8 -> one pulse enable=5'b00100; addr=0x1F; data=0x0ABC; 0 errors.
2. Burst of frames 0x00_01_3FFF and 0x04_02_0010 under one CS_n -> enable 5'b00001 then 5'b10000, one cycle each; final addr=0x02, data=0x0010.
3. CS_n raised after 20 bits, then a full frame 0x03_05_0123 -> only one pulse (5'b01000, addr 0x05); error count stays 0.
4. Frame 0x07_00_FFFF -> no enable; error count 1; addr/data keep prior values. 256 more bad frames -> count saturates at 255.
5. i_Reset_n low for one cycle at bit 16 of frame 0x01_10_1234, then frame 0x01_11_5678 -> only the second write occurs (enable 5'b00010, addr 0x11, data 0x5678).
6. (ECHO_EN) frame A=0x02_1F_0ABC, then any frame B -> MISO during B reads 0x021F0ABC MSB-first; after bad frame C, the next frame reads 0xFFFFFFFF.
